// File: rtl/multdiv_ctrl.sv
// ============================================================================
// multdiv_ctrl: launch/stall/writeback sequencer for the shared mul/div unit.
// Optional watchdog abort: define MULTDIV_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multdiv_ctrl #(
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dx_valid,
  input  logic [4:0]  dx_opcode,
  input  logic [4:0]  dx_aluop,
  input  logic [4:0]  dx_rd,
  output logic        md_start_mult,
  output logic        md_start_div,
  input  logic        md_ready,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        md_abort,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data,
  output logic        stall,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int              c_CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]      c_STATUS_REG = 5'd30;
`ifdef MULTDIV_TIMEOUT_EN
  localparam logic c_TO_EN = 1'b1;
`else
  localparam logic c_TO_EN = 1'b0;
`endif

  state_t            r_state;
  state_t            w_next;
  logic [4:0]        r_rd;
  logic              r_is_div;
  logic [31:0]       r_result;
  logic              r_exc;
  logic [c_CW-1:0]   r_cnt;
  logic              w_is_mul;
  logic              w_is_div;
  logic              w_timeout;

  assign w_is_mul  = dx_valid && (dx_opcode == 5'b00000) && (dx_aluop == 5'b00110);
  assign w_is_div  = dx_valid && (dx_opcode == 5'b00000) && (dx_aluop == 5'b00111);
  // r_cnt holds the number of BUSY cycles already completed
  assign w_timeout = c_TO_EN && (r_cnt == c_LAST);

  always_comb begin
    w_next        = r_state;
    md_start_mult = 1'b0;
    md_start_div  = 1'b0;
    md_abort      = 1'b0;
    stall         = 1'b0;
    busy          = (r_state != IDLE);
    rf_we         = wb_we;
    rf_rd         = wb_rd;
    rf_data       = wb_data;
    case (r_state)
      IDLE: begin
        if (w_is_mul || w_is_div) begin
          md_start_mult = w_is_mul;
          md_start_div  = w_is_div;
          stall         = 1'b1;
          w_next        = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (md_ready) begin
          w_next = DONE;
        end else if (w_timeout) begin
          md_abort = 1'b1;
          w_next   = DONE;
        end
      end
      DONE: begin
        if (wb_we) begin
          stall = 1'b1;
        end else begin
          // An exception write to the status register replaces the rd write.
          rf_we   = r_exc || (r_rd != 5'd0);
          rf_rd   = r_exc ? c_STATUS_REG : r_rd;
          rf_data = r_exc ? (r_is_div ? 32'd5 : 32'd4) : r_result;
          w_next  = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_rd     <= 5'd0;
      r_is_div <= 1'b0;
      r_result <= 32'd0;
      r_exc    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_is_mul || w_is_div) begin
            r_rd     <= dx_rd;
            r_is_div <= w_is_div;
            r_cnt    <= '0;
          end
        end
        BUSY: begin
          r_cnt <= r_cnt + c_CW'(1);
          if (md_ready) begin
            r_result <= md_result;
            r_exc    <= md_exception;
          end else if (w_timeout) begin
            r_exc    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multdiv_ctrl.sv
// ============================================================================
// tb_multdiv_ctrl: randomized scoreboard bench for multdiv_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multdiv_ctrl;

  localparam int c_TO = 40;

  logic        clock;
  logic        reset;
  logic        dx_valid;
  logic [4:0]  dx_opcode;
  logic [4:0]  dx_aluop;
  logic [4:0]  dx_rd;
  logic        md_start_mult;
  logic        md_start_div;
  logic        md_ready;
  logic        md_exception;
  logic [31:0] md_result;
  logic        md_abort;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic        stall;
  logic        busy;

  multdiv_ctrl #(.TIMEOUT_CYCLES(c_TO)) u_dut (
    .clock(clock), .reset(reset),
    .dx_valid(dx_valid), .dx_opcode(dx_opcode), .dx_aluop(dx_aluop), .dx_rd(dx_rd),
    .md_start_mult(md_start_mult), .md_start_div(md_start_div),
    .md_ready(md_ready), .md_exception(md_exception), .md_result(md_result),
    .md_abort(md_abort),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data),
    .stall(stall), .busy(busy)
  );

  typedef struct packed {
    logic smul;
    logic sdiv;
    logic stl;
    logic bsy;
    logic abrt;
  } ctl_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  ctl_t ctl_q[$];
  wr_t  wr_q[$];
  int   checks   = 0;
  int   failures = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: per-cycle control outputs, plus every presented rf write.
  always @(negedge clock) begin
    if (ctl_q.size() > 0) begin
      ctl_t e;
      ctl_t a;
      e = ctl_q.pop_front();
      a = {md_start_mult, md_start_div, stall, busy, md_abort};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL ctl t=%0t got smul/sdiv/stall/busy/abort=%b want %b", $time, a, e);
      end
      if (rf_we === 1'b1) begin
        checks++;
        if (wr_q.size() == 0) begin
          failures++;
          $display("FAIL rf_write t=%0t unexpected write rd=%0d data=%h", $time, rf_rd, rf_data);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          if ({rf_rd, rf_data} !== w) begin
            failures++;
            $display("FAIL rf_write t=%0t got rd=%0d data=%h want rd=%0d data=%h",
                     $time, rf_rd, rf_data, w.rd, w.data);
          end
        end
      end else if (rf_we !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL rf_we t=%0t got %b want 0/1", $time, rf_we);
      end
    end
  end

  function automatic ctl_t mk(input logic m, input logic d, input logic s,
                              input logic b, input logic a);
    return {m, d, s, b, a};
  endfunction

  task automatic step(input ctl_t e, input logic cw, input wr_t w);
    ctl_q.push_back(e);
    if (wb_we) wr_q.push_back({wb_rd, wb_data});
    else if (cw) wr_q.push_back(w);
    @(posedge clock);
    #1;
  endtask

  task automatic rand_wb();
    wb_we   = ($urandom_range(0, 2) == 0);
    wb_rd   = 5'($urandom);
    wb_data = $urandom;
  endtask

  // Idle cycle with a D/X instruction that must not launch and a stray md_ready.
  task automatic idle();
    int mode;
    mode      = $urandom_range(0, 2);
    dx_rd     = 5'($urandom);
    dx_valid  = (mode != 0);
    dx_opcode = (mode == 1) ? 5'($urandom_range(1, 31)) : 5'd0;
    dx_aluop  = (mode == 2) ? 5'($urandom_range(8, 31)) : 5'(6 + $urandom_range(0, 1));
    md_ready  = $urandom_range(0, 1);
    md_exception = $urandom_range(0, 1);
    md_result = $urandom;
    rand_wb();
    step(mk(0, 0, 0, 0, 0), 1'b0, '0);
  endtask

  task automatic do_op(input logic div, input logic [4:0] rd, input int lat,
                       input logic exc, input int wbk, input logic [31:0] res,
                       input logic to);
    logic exc_eff;
    wr_t  w;
    dx_valid  = 1'b1;
    dx_opcode = 5'd0;
    dx_aluop  = div ? 5'b00111 : 5'b00110;
    dx_rd     = rd;
    md_ready  = 1'b0;
    md_result = $urandom;
    rand_wb();
    step(mk(!div, div, 1, 0, 0), 1'b0, '0);
    for (int b = 1; b <= lat; b++) begin
      md_ready     = !to && (b == lat);
      md_exception = (b == lat) ? exc : 1'($urandom);
      md_result    = (b == lat) ? res : $urandom;
      rand_wb();
      step(mk(0, 0, 1, 1, to && (b == c_TO)), 1'b0, '0);
    end
    exc_eff = exc || to;
    for (int k = 0; k < wbk; k++) begin
      md_ready  = $urandom_range(0, 1);
      md_result = $urandom;
      wb_we     = 1'b1;
      wb_rd     = 5'($urandom);
      wb_data   = $urandom;
      step(mk(0, 0, 1, 1, 0), 1'b0, '0);
    end
    md_ready  = $urandom_range(0, 1);
    md_result = $urandom;
    wb_we     = 1'b0;
    w.rd      = exc_eff ? 5'd30 : rd;
    w.data    = exc_eff ? (div ? 32'd5 : 32'd4) : res;
    step(mk(0, 0, 0, 1, 0), exc_eff || (rd != 5'd0), w);
    dx_valid = 1'b0;
    md_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    dx_valid = 1'b0; dx_opcode = 5'd0; dx_aluop = 5'd0; dx_rd = 5'd0;
    md_ready = 1'b0; md_exception = 1'b0; md_result = 32'd0;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      rand_wb();
      wb_we = 1'b1;
      step(mk(0, 0, 0, 0, 0), 1'b0, '0);
    end
    reset = 1'b0;
    idle();

    do_op(1'b0, 5'd5, 3, 1'b0, 0, 32'h0000_0030, 1'b0);
    idle();
    do_op(1'b1, 5'd7, 2, 1'b1, 0, $urandom, 1'b0);
    do_op(1'b0, 5'd12, 1, 1'b0, 2, $urandom, 1'b0);
    do_op(1'b0, 5'd0, 2, 1'b0, 0, $urandom, 1'b0);
    do_op(1'b1, 5'd0, 1, 1'b1, 1, $urandom, 1'b0);
    idle();

    // Asynchronous reset while BUSY discards the operation.
    dx_valid = 1'b1; dx_opcode = 5'd0; dx_aluop = 5'b00110; dx_rd = 5'd9;
    md_ready = 1'b0;
    rand_wb();
    step(mk(1, 0, 1, 0, 0), 1'b0, '0);
    rand_wb();
    step(mk(0, 0, 1, 1, 0), 1'b0, '0);
    reset = 1'b1;
    dx_valid = 1'b0;
    wb_we = 1'b0;
    step(mk(0, 0, 0, 0, 0), 1'b0, '0);
    reset = 1'b0;
    md_ready = 1'b1;
    md_result = $urandom;
    step(mk(0, 0, 0, 0, 0), 1'b0, '0);
    md_ready = 1'b0;
    do_op(1'b0, 5'd9, 2, 1'b0, 0, $urandom, 1'b0);

`ifdef MULTDIV_TIMEOUT_EN
    do_op(1'b0, 5'd11, c_TO, 1'b0, 0, $urandom, 1'b1);
    do_op(1'b1, 5'd11, c_TO, 1'b0, 1, $urandom, 1'b0);
`endif

    for (int n = 0; n < 30; n++) begin
      int gap;
      logic [4:0] rd;
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      do_op(1'($urandom), rd, $urandom_range(1, 5), ($urandom_range(0, 3) == 0),
            $urandom_range(0, 2), $urandom, 1'b0);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle();
    end
    idle();

    checks++;
    if (ctl_q.size() != 0 || wr_q.size() != 0) begin
      failures++;
      $display("FAIL drain got ctl_q=%0d wr_q=%0d want 0/0", ctl_q.size(), wr_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
